// File: rtl/branch_predict_btb_if.sv
// Prediction and resolution bus between fetch/execute and the BTB.
interface branch_predict_btb_if;
    // Fetch-side lookup
    logic [31:0] pred_pc_i;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    // Execute-side resolution
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic        res_cond_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        res_pred_taken_i;
    logic [31:0] res_pred_target_i;
    // Redirect and statistics
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] br_cnt_o;
    logic [31:0] mispred_cnt_o;

    modport master (
        output pred_pc_i, res_valid_i, res_pc_i, res_cond_i, res_taken_i,
               res_target_i, res_pred_taken_i, res_pred_target_i,
        input  pred_hit_o, pred_taken_o, pred_target_o, mispredict_o,
               redirect_pc_o, br_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pred_pc_i, res_valid_i, res_pc_i, res_cond_i, res_taken_i,
               res_target_i, res_pred_taken_i, res_pred_target_i,
        output pred_hit_o, pred_taken_o, pred_target_o, mispredict_o,
               redirect_pc_o, br_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_predict_btb.sv
// Direct-mapped BTB with 2-bit counters, mispredict redirect and statistics.
module branch_predict_btb #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned TAG_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predict_btb_if.slave  bus
);
    localparam int unsigned IDX_W  = $clog2(ENTRIES);
    localparam int unsigned IDX_LO = 2;
    localparam int unsigned IDX_HI = IDX_W + 1;
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = IDX_W + TAG_W + 1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic        mispredict_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_cnt_q;
    logic [31:0] mispred_cnt_q;

    logic [IDX_W-1:0] pred_idx;
    logic [TAG_W-1:0] pred_tag;
    logic             pred_hit;
    logic             pred_taken;
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic [1:0]       res_cnt;

    logic             wr_en;
    logic [31:0]      wr_target;
    logic [1:0]       wr_cnt;
    logic             mispredict_c;
    logic [31:0]      redirect_c;
    logic             unused_pc_bits;

    assign pred_idx = bus.pred_pc_i[IDX_HI:IDX_LO];
    assign pred_tag = bus.pred_pc_i[TAG_HI:TAG_LO];
    assign res_idx  = bus.res_pc_i[IDX_HI:IDX_LO];
    assign res_tag  = bus.res_pc_i[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{bus.pred_pc_i, bus.res_pc_i};

    // Same-cycle fetch lookup; reads pre-edge table contents.
    always_comb begin
        pred_hit   = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
        pred_taken = pred_hit && cnt_q[pred_idx][1];
    end

    assign bus.pred_hit_o    = pred_hit;
    assign bus.pred_taken_o  = pred_taken;
    assign bus.pred_target_o = pred_taken ? target_q[pred_idx]
                                          : 32'(bus.pred_pc_i + 32'd4);

    // Table update decision and mispredict detection for the resolving branch.
    always_comb begin
        res_hit      = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        res_cnt      = cnt_q[res_idx];
        wr_en        = 1'b0;
        wr_target    = target_q[res_idx];
        wr_cnt       = res_cnt;
        mispredict_c = (bus.res_taken_i != bus.res_pred_taken_i) ||
                       (bus.res_taken_i && (bus.res_target_i != bus.res_pred_target_i));
        redirect_c   = bus.res_taken_i ? bus.res_target_i : 32'(bus.res_pc_i + 32'd4);
        if (bus.res_valid_i) begin
            if (!bus.res_cond_i) begin
                wr_en     = 1'b1;
                wr_target = bus.res_target_i;
                wr_cnt    = 2'b11;
            end else if (bus.res_taken_i) begin
                wr_en     = 1'b1;
                wr_target = bus.res_target_i;
                if (!res_hit) begin
                    wr_cnt = 2'b10;
                end else if (res_cnt != 2'b11) begin
                    wr_cnt = 2'(res_cnt + 2'd1);
                end
            end else if (res_hit) begin
                wr_en = 1'b1;
                if (res_cnt != 2'b00) begin
                    wr_cnt = 2'(res_cnt - 2'd1);
                end
            end
        end
    end

    // Table write, redirect strobe and saturating statistics; reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            tag_q         <= '{default: '0};
            target_q      <= '{default: '0};
            cnt_q         <= '{default: '0};
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            mispredict_q <= 1'b0;
            if (bus.res_valid_i) begin
                mispredict_q  <= mispredict_c;
                redirect_pc_q <= redirect_c;
                if (br_cnt_q != 32'hFFFF_FFFF) begin
                    br_cnt_q <= br_cnt_q + 32'd1;
                end
                if (mispredict_c && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
                    mispred_cnt_q <= mispred_cnt_q + 32'd1;
                end
            end
            if (wr_en) begin
                valid_q[res_idx]  <= 1'b1;
                tag_q[res_idx]    <= res_tag;
                target_q[res_idx] <= wr_target;
                cnt_q[res_idx]    <= wr_cnt;
            end
        end
    end

    assign bus.mispredict_o  = mispredict_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.br_cnt_o      = br_cnt_q;
    assign bus.mispred_cnt_o = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_btb.sv
// Directed vector bench for branch_predict_btb (ENTRIES=16, TAG_W=8).
module tb_branch_predict_btb;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_predict_btb_if bus ();

    branch_predict_btb #(.ENTRIES(16), .TAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] pred_pc;
        logic        rv;
        logic        rc;
        logic        rt;
        logic [31:0] rpc;
        logic [31:0] rtgt;
        logic        rpt;
        logic [31:0] rptgt;
        logic        ehit;
        logic        etaken;
        logic [31:0] etgt;
        logic        emis;
        logic [31:0] eredir;
        logic [31:0] ebr;
        logic [31:0] emc;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_res(input logic rv, input logic rc, input logic rt, input logic [31:0] rpc,
                             input logic [31:0] rtgt, input logic rpt, input logic [31:0] rptgt);
        bus.res_valid_i       = rv;
        bus.res_cond_i        = rc;
        bus.res_taken_i       = rt;
        bus.res_pc_i          = rpc;
        bus.res_target_i      = rtgt;
        bus.res_pred_taken_i  = rpt;
        bus.res_pred_target_i = rptgt;
    endtask

    initial begin
        vecs[0]  = '{32'h1C000000, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h1C000004, 0, 32'h0,        32'd0,  32'd0};
        vecs[1]  = '{32'h1C000010, 1, 1, 1, 32'h1C000010, 32'h1C000100, 0, 32'h1C000014, 0, 0, 32'h1C000014, 1, 32'h1C000100, 32'd1,  32'd1};
        vecs[2]  = '{32'h1C000010, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h1C000100, 0, 32'h1C000100, 32'd1,  32'd1};
        vecs[3]  = '{32'h1C000010, 1, 1, 0, 32'h1C000010, 32'h0,        1, 32'h1C000100, 1, 1, 32'h1C000100, 1, 32'h1C000014, 32'd2,  32'd2};
        vecs[4]  = '{32'h1C000010, 1, 1, 0, 32'h1C000010, 32'h0,        0, 32'h1C000014, 1, 0, 32'h1C000014, 0, 32'h1C000014, 32'd3,  32'd2};
        vecs[5]  = '{32'h1C000010, 1, 1, 0, 32'h1C000010, 32'h0,        0, 32'h1C000014, 1, 0, 32'h1C000014, 0, 32'h1C000014, 32'd4,  32'd2};
        vecs[6]  = '{32'h1C000010, 1, 1, 1, 32'h1C000010, 32'h1C000100, 0, 32'h1C000014, 1, 0, 32'h1C000014, 1, 32'h1C000100, 32'd5,  32'd3};
        vecs[7]  = '{32'h1C000010, 1, 0, 1, 32'h1C000020, 32'h1C000300, 1, 32'h1C000200, 1, 0, 32'h1C000014, 1, 32'h1C000300, 32'd6,  32'd4};
        vecs[8]  = '{32'h1C000020, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h1C000300, 0, 32'h1C000300, 32'd6,  32'd4};
        vecs[9]  = '{32'h1C000050, 1, 1, 1, 32'h1C000050, 32'h1C000500, 0, 32'h1C000054, 0, 0, 32'h1C000054, 1, 32'h1C000500, 32'd7,  32'd5};
        vecs[10] = '{32'h1C000050, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h1C000500, 0, 32'h1C000500, 32'd7,  32'd5};
        vecs[11] = '{32'h1C000010, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h1C000014, 0, 32'h1C000500, 32'd7,  32'd5};
        vecs[12] = '{32'h1C000020, 1, 0, 1, 32'h1C000020, 32'h1C000400, 1, 32'h1C000300, 1, 1, 32'h1C000300, 1, 32'h1C000400, 32'd8,  32'd6};
        vecs[13] = '{32'h1C000020, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        1, 1, 32'h1C000400, 0, 32'h1C000400, 32'd8,  32'd6};
        vecs[14] = '{32'h1C000020, 1, 1, 1, 32'h1C000020, 32'h1C000400, 1, 32'h1C000400, 1, 1, 32'h1C000400, 0, 32'h1C000400, 32'd9,  32'd6};
        vecs[15] = '{32'h1C000000, 1, 1, 0, 32'h1C000000, 32'h0,        0, 32'h1C000004, 0, 0, 32'h1C000004, 0, 32'h1C000004, 32'd10, 32'd6};
        vecs[16] = '{32'h1C000000, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        0, 0, 32'h1C000004, 0, 32'h1C000004, 32'd10, 32'd6};

        reset = 1'b1;
        bus.pred_pc_i = 32'h1C000000;
        drive_res(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven sequence: lookup checked before the edge, registered outputs after.
        for (int i = 0; i < 17; i++) begin
            bus.pred_pc_i = vecs[i].pred_pc;
            drive_res(vecs[i].rv, vecs[i].rc, vecs[i].rt, vecs[i].rpc,
                      vecs[i].rtgt, vecs[i].rpt, vecs[i].rptgt);
            #1;
            chk($sformatf("v%0d_hit", i),    32'(bus.pred_hit_o),   32'(vecs[i].ehit));
            chk($sformatf("v%0d_taken", i),  32'(bus.pred_taken_o), 32'(vecs[i].etaken));
            chk($sformatf("v%0d_ptgt", i),   bus.pred_target_o,     vecs[i].etgt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_mis", i),    32'(bus.mispredict_o), 32'(vecs[i].emis));
            chk($sformatf("v%0d_redir", i),  bus.redirect_pc_o,     vecs[i].eredir);
            chk($sformatf("v%0d_br", i),     bus.br_cnt_o,          vecs[i].ebr);
            chk($sformatf("v%0d_mcnt", i),   bus.mispred_cnt_o,     vecs[i].emc);
            @(negedge clk);
        end

        // Statistics saturation from a preloaded near-max value.
        drive_res(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        force dut.br_cnt_q = 32'hFFFF_FFFE;
        force dut.mispred_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.br_cnt_q;
        release dut.mispred_cnt_q;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_res(1, 1, 1, 32'h1C000030, 32'h1C000700, 0, 32'h1C000034);
            @(posedge clk);
            #1;
            chk($sformatf("sat%0d_mis", k),  32'(bus.mispredict_o), 32'd1);
            chk($sformatf("sat%0d_br", k),   bus.br_cnt_o,          32'hFFFF_FFFF);
            chk($sformatf("sat%0d_mcnt", k), bus.mispred_cnt_o,     32'hFFFF_FFFF);
        end

        // Reset asserted together with a mispredicting resolve.
        @(negedge clk);
        reset = 1'b1;
        drive_res(1, 0, 1, 32'h1C000040, 32'h1C000800, 0, 32'h1C000044);
        @(posedge clk);
        #1;
        chk("rst_mis",   32'(bus.mispredict_o), 32'd0);
        chk("rst_redir", bus.redirect_pc_o,     32'h0);
        chk("rst_br",    bus.br_cnt_o,          32'd0);
        chk("rst_mcnt",  bus.mispred_cnt_o,     32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_res(0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            bus.pred_pc_i = 32'h1C000010 + 32'(k) * 32'h10;
            #1;
            chk($sformatf("rst_hit_%h", bus.pred_pc_i), 32'(bus.pred_hit_o), 32'd0);
            chk($sformatf("rst_ptgt_%h", bus.pred_pc_i), bus.pred_target_o,
                32'h1C000014 + 32'(k) * 32'h10);
        end
        @(posedge clk);
        #1;
        chk("post_rst_mis", 32'(bus.mispredict_o), 32'd0);
        chk("post_rst_br",  bus.br_cnt_o,          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predict_btb.md
# branch_predict_btb

Parametrised branch prediction and resolution unit: a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters. It gives a same-cycle taken/target prediction to the fetch stage. It accepts resolved branch outcomes from the execute stage, updates the table, and raises a registered one-cycle redirect on misprediction. It also keeps saturating branch and misprediction statistics counters.

## Interface
Parameters:
- ENTRIES, 16: BTB entries; power of two, ≥2. IDX_W = clog2(ENTRIES).
- TAG_W, 8: stored tag width; IDX_W+TAG_W+2 ≤ 32.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pred_pc_i  in  32  fetch PC to predict
- pred_hit_o  out  1  valid entry with matching tag
- pred_taken_o  out  1  predicted taken
- pred_target_o  out  32  predicted next PC
- res_valid_i  in  1  one resolved branch this cycle (single-cycle pulse per branch)
- res_pc_i  in  32  PC of resolved branch
- res_cond_i  in  1  1 = conditional (BEQ..BGEU); 0 = unconditional (B/BL/JIRL)
- res_taken_i  in  1  actual direction
- res_target_i  in  32  actual taken target
- res_pred_taken_i  in  1  prediction carried down the pipe for this branch
- res_pred_target_i  in  32  predicted next PC carried down the pipe
- mispredict_o  out  1  registered redirect strobe
- redirect_pc_o  out  32  registered correct next PC
- br_cnt_o  out  32  resolved branches, saturating
- mispred_cnt_o  out  32  mispredictions, saturating

## Operation
- Addressing: index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid, tag[TAG_W], target[32], cnt[2].
- Lookup is combinational:
  - hit = valid && tag match.
  - pred_taken_o = hit && cnt[1].
  - pred_target_o = pred_taken_o ? target : pred_pc_i+4 (mod 2^32).
- Update happens on res_valid_i, written at the clock edge. Let h = hit for res_pc_i.
  - Unconditional: write valid=1, tag, target=res_target_i, cnt=2'b11.
  - Conditional, taken, h=1: target=res_target_i; cnt saturating +1 (max 11).
  - Conditional, taken, h=0: allocate and overwrite any aliasing entry; cnt=2'b10.
  - Conditional, not taken, h=1: cnt saturating −1 (min 00); target unchanged.
  - Conditional, not taken, h=0: no write.
- Mispredict condition, evaluated on res_valid_i: (res_taken_i != res_pred_taken_i) || (res_taken_i && res_target_i != res_pred_target_i).
  - Register mispredict_o = condition.
  - Register redirect_pc_o = res_taken_i ? res_target_i : res_pc_i+4.
  - When res_valid_i=0, mispredict_o goes to 0 and redirect_pc_o holds its value.
- Statistics:
  - br_cnt_o increments on each res_valid_i.
  - mispred_cnt_o increments on each mispredict.
  - Both saturate at 32'hFFFF_FFFF.

## Timing
- Lookup latency is 0 cycles (same-cycle combinational).
- A table update sampled at edge N is visible to lookups from cycle N+1. A same-cycle lookup of the index being written returns the old contents.
- mispredict_o and redirect_pc_o are valid in the cycle after res_valid_i and last exactly one cycle per mispredicted branch. Back-to-back mispredicts give back-to-back pulses.
- Reset values:
  - All valid bits 0. cnt and target are don't-care but must be written to 0.
  - mispredict_o 0, redirect_pc_o 0, br_cnt_o 0, mispred_cnt_o 0.
- Reset dominates: with reset=1, res_valid_i is ignored, with no table write and no counter increment.
- At the edge after reset deasserts, normal operation resumes.

## Test plan
- Reset, then pred_pc_i=0x1C000000 → hit 0, taken 0, target 0x1C000004; all outputs 0.
- Conditional taken at 0x1C000010, target 0x1C000100, pred_taken 0 → next cycle mispredict_o=1, redirect_pc_o=0x1C000100, br_cnt_o=1, mispred_cnt_o=1. Lookup 0x1C000010 then gives hit 1, taken 1, target 0x1C000100.
- Three not-taken resolves on 0x1C000010 → cnt 10→01→00→00 (saturation). Pred_taken becomes 0 after the first. The third, with pred_taken 0, gives mispredict_o=0 and redirect_pc_o unchanged.
- JIRL (res_cond_i=0) at 0x1C000020, predicted 0x1C000200, actual 0x1C000300 → mispredict_o=1, redirect 0x1C000300; entry cnt=11, target 0x1C000300.
- Aliasing with ENTRIES=16: taken at 0x1C000010, then taken at 0x1C000050 (same index, different tag) → 0x1C000050 hits; 0x1C000010 misses with pred_target 0x1C000014. Also: lookup and update of the same PC in one cycle → old prediction that cycle, new prediction the next.
- Reset asserted mid-stream together with res_valid_i and a mispredicting branch → no pulse next cycle, counters 0, all lookups miss; br_cnt_o saturation checked by preloading force to 0xFFFFFFFE plus two resolves → 0xFFFFFFFF.
